// File: rtl/piso_stream_if.sv
// Word-in / beat-out handshake bundle for piso_stream; the slave modport is the
// serializer's view, the master modport is the view of whatever drives and consumes it.
interface piso_stream_if #(
  parameter int SIZE_DATA_IN  = 16,
  parameter int SIZE_DATA_OUT = 2
);
  localparam int DEPTH      = SIZE_DATA_IN / SIZE_DATA_OUT;
  localparam int SIZE_DEPTH = $clog2(DEPTH);

  logic                     i_valid;
  logic                     o_ready;
  logic [SIZE_DATA_IN-1:0]  i_data;
  logic                     i_msb_first;
  logic                     o_valid;
  logic                     i_ready;
  logic [SIZE_DATA_OUT-1:0] o_data;
  logic                     o_last;
  logic [SIZE_DEPTH-1:0]    o_count;
  logic                     o_busy;

  modport slave (
    input  i_valid, i_data, i_msb_first, i_ready,
    output o_ready, o_valid, o_data, o_last, o_count, o_busy
  );

  modport master (
    output i_valid, i_data, i_msb_first, i_ready,
    input  o_ready, o_valid, o_data, o_last, o_count, o_busy
  );
endinterface

// File: rtl/piso_stream.sv
// Parallel-in/serial-out serializer: one SIZE_DATA_IN word out as DEPTH beats, LSB- or MSB-slice first.
// Define PISO_STREAM_PREFETCH_EN to add a one-word holding register for bubble-free back-to-back words.
module piso_stream #(
  parameter int SIZE_DATA_IN  = 16,
  parameter int SIZE_DATA_OUT = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  piso_stream_if.slave  bus
);
  localparam int DEPTH      = SIZE_DATA_IN / SIZE_DATA_OUT;
  localparam int SIZE_DEPTH = $clog2(DEPTH);
  localparam logic [SIZE_DEPTH-1:0] LAST_IDX = SIZE_DEPTH'(DEPTH - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [SIZE_DATA_IN-1:0] shift_q, shift_d;
  logic                    msb_q, msb_d;
  logic [SIZE_DEPTH-1:0]   idx_q, idx_d;

  logic                     ready, valid, accept, xfer, last;
  logic [SIZE_DATA_OUT-1:0] beat;

`ifdef PISO_STREAM_PREFETCH_EN
  logic [SIZE_DATA_IN-1:0] hold_q, hold_d;
  logic                    hold_msb_q, hold_msb_d;
  logic                    hold_full_q, hold_full_d;
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default every comb output first so no path leaves it unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = SHIFT;
      SHIFT: begin
        if (xfer && last) begin
`ifdef PISO_STREAM_PREFETCH_EN
          if (!(hold_full_q || accept)) state_d = IDLE;
`else
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: decoded purely from registered state, never from i_valid/i_data.
  always_comb begin
    valid = 1'b0;
    ready = 1'b1;
    if (state_q == SHIFT) begin
      valid = 1'b1;
`ifdef PISO_STREAM_PREFETCH_EN
      ready = ~hold_full_q;
`else
      ready = 1'b0;
`endif
    end
  end

  assign accept = bus.i_valid & ready;
  assign xfer   = valid & bus.i_ready;
  assign last   = valid & (idx_q == LAST_IDX);
  // LSB-first words shift right and emit the low slice; MSB-first shift left and emit the high slice.
  assign beat   = msb_q ? shift_q[SIZE_DATA_IN-1 -: SIZE_DATA_OUT] : shift_q[SIZE_DATA_OUT-1:0];

  assign bus.o_ready = ready;
  assign bus.o_valid = valid;
  assign bus.o_busy  = valid;
  assign bus.o_last  = last;
  assign bus.o_data  = valid ? beat  : '0;
  assign bus.o_count = valid ? idx_q : '0;

  // Datapath next-state: load on accept, advance on transfer.
  always_comb begin
    shift_d = shift_q;
    msb_d   = msb_q;
    idx_d   = idx_q;
`ifdef PISO_STREAM_PREFETCH_EN
    hold_d      = hold_q;
    hold_msb_d  = hold_msb_q;
    hold_full_d = hold_full_q;
`endif
    if (state_q == IDLE) begin
      if (accept) begin
        shift_d = bus.i_data;
        msb_d   = bus.i_msb_first;
        idx_d   = '0;
      end
    end else if (xfer) begin
      if (last) begin
        idx_d = '0;
`ifdef PISO_STREAM_PREFETCH_EN
        if (hold_full_q) begin
          shift_d     = hold_q;
          msb_d       = hold_msb_q;
          hold_full_d = 1'b0;
        end else if (accept) begin
          shift_d = bus.i_data;
          msb_d   = bus.i_msb_first;
        end
`endif
      end else begin
        idx_d   = idx_q + SIZE_DEPTH'(1);
        shift_d = msb_q ? (shift_q << SIZE_DATA_OUT) : (shift_q >> SIZE_DATA_OUT);
      end
    end
`ifdef PISO_STREAM_PREFETCH_EN
    // A word accepted mid-word parks in the hold register until the last beat leaves.
    if ((state_q == SHIFT) && accept && !(xfer && last)) begin
      hold_d      = bus.i_data;
      hold_msb_d  = bus.i_msb_first;
      hold_full_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      idx_q <= '0;
`ifdef PISO_STREAM_PREFETCH_EN
      hold_full_q <= 1'b0;
`endif
    end else begin
      idx_q <= idx_d;
`ifdef PISO_STREAM_PREFETCH_EN
      hold_full_q <= hold_full_d;
`endif
    end
  end

  // NOTE: word storage carries no reset; its contents are only observed while valid/full flags say so.
  always_ff @(posedge i_clk) begin
    shift_q <= shift_d;
    msb_q   <= msb_d;
`ifdef PISO_STREAM_PREFETCH_EN
    hold_q     <= hold_d;
    hold_msb_q <= hold_msb_d;
`endif
  end
endmodule

// File: doc/piso_stream.md
Name: piso_stream

Overview:
Parametrised parallel-in/serial-out serializer with valid/ready handshakes on both sides. It accepts one SIZE_DATA_IN-bit word and emits it as DEPTH beats of SIZE_DATA_OUT bits, LSB-slice-first or MSB-slice-first, selected per word. It stalls cleanly under downstream backpressure. It replaces the fixed 16-to-2 serializer in the link transmit path and feeds the lane driver.

Parameters:
SIZE_DATA_IN, 16, parallel input word width; must be an integer multiple of SIZE_DATA_OUT.
SIZE_DATA_OUT, 2, serial beat width.
DEPTH, SIZE_DATA_IN/SIZE_DATA_OUT, beats per word; derived localparam, not overridable; must be >= 2.
SIZE_DEPTH, $clog2(DEPTH), beat index width; derived localparam.

Ports:
i_clk  input  1  clock, rising edge.
i_rst_n  input  1  reset; synchronous, active-low.
i_valid  input  1  upstream word valid.
o_ready  output  1  block can accept a word this cycle.
i_data  input  SIZE_DATA_IN  parallel word; sampled on accept.
i_msb_first  input  1  slice order for this word; sampled on accept.
o_valid  output  1  o_data holds a valid beat.
i_ready  input  1  downstream accepts the beat this cycle.
o_data  output  SIZE_DATA_OUT  current beat; forced to 0 when o_valid=0.
o_last  output  1  current beat is the final beat of the word (o_valid & beat index = DEPTH-1).
o_count  output  SIZE_DEPTH  index of the current beat; 0 when idle.
o_busy  output  1  a word is being serialized (FSM in SHIFT).

Behaviour:
- Reset (i_rst_n=0 at a rising edge) forces: FSM=IDLE, o_valid=0, o_data=0, o_last=0, o_count=0, o_busy=0. o_ready=1 from the first cycle after reset release.
- Accept: occurs when i_valid & o_ready at a rising edge. The block captures i_data into the shift register and i_msb_first into the mode flag, and sets the beat index to 0.
- Handshake: a beat transfers when o_valid & i_ready at a rising edge. When o_valid=1 and i_ready=0, o_data, o_count and o_last hold stable. o_valid never drops without a transfer.
- Slice order: beat k = i_data[k*SIZE_DATA_OUT +: SIZE_DATA_OUT] when LSB-first. When MSB-first, beat k = slice (DEPTH-1-k).
- FSM, IDLE: o_ready=1, o_valid=0. Accept moves to SHIFT.
- FSM, SHIFT: o_valid=1 and o_busy=1.
  - Each beat transfer increments the index.
  - A transfer with index=DEPTH-1 returns to IDLE; with the optional feature, see below.
  - o_ready=0 throughout SHIFT (base build).
- Latency: the first beat is valid in the cycle after the accepting edge. Base throughput is DEPTH+1 cycles per word at i_ready=1 (one idle/accept bubble).
- Index arithmetic: SIZE_DEPTH bits. It never wraps past DEPTH-1 for non-power-of-2 DEPTH; it resets to 0 on word completion.
- The output register is updated on the transfer edge. There is no combinational path from i_valid or i_data to o_data.
- Simultaneous i_valid in SHIFT (base build): ignored, since o_ready=0. Upstream must hold i_valid.
- Reset mid-word: the word in flight is discarded; no further beats are emitted.
- i_msb_first changing during SHIFT has no effect on the current word.

Optional Feature:
Macro PISO_STREAM_PREFETCH_EN.
- Defined:
  - Adds a one-word holding register (data + mode) with a full flag.
  - In SHIFT, o_ready = ~hold_full, and an accept in SHIFT fills the hold register.
  - On the last-beat transfer:
    - If hold is full, the shift register loads from hold, hold empties, and the FSM stays in SHIFT with index 0 next cycle.
    - Else if i_valid is high the same cycle, the word loads directly into the shift register and the FSM stays in SHIFT.
    - Otherwise the FSM goes to IDLE.
  - Throughput is DEPTH cycles per word with no bubble.
  - Reset clears hold_full.
- Undefined: behaviour is exactly the base build; no hold register.

Test Plan:
1. LSB-first, i_data=16'hB4E1, i_ready=1 -> o_data beats 1,0,2,3,0,1,3,2; o_last only on the 8th beat; o_count 0..7.
2. MSB-first, same word -> beats 2,3,1,0,3,2,0,1; o_ready=0 during all 8 beats and =1 the cycle after.
3. Backpressure: i_ready=0 for 3 cycles at beat 4 of 16'hB4E1 LSB-first -> o_data=0 and o_count=4 held stable; sequence is otherwise unchanged; no beat is lost or duplicated.
4. Back-to-back: two words with i_valid held high and i_ready=1 -> base build 9 cycles/word with one o_valid=0 gap; with PISO_STREAM_PREFETCH_EN, 8 cycles/word and no gap.
5. Reset: assert i_rst_n=0 after beat 3 -> next cycle o_valid=0, o_data=0, o_count=0, o_ready=1; a fresh word restarts at beat 0.
6. SIZE_DATA_IN=32, SIZE_DATA_OUT=8, i_data=32'hDEADBEEF LSB-first -> beats EF,BE,AD,DE; MSB-first -> DE,AD,BE,EF.
